// File: rtl/twilight_fade_ctrl.sv
// Day/night fade sequencer: DAY hold, DUSK fade-down, NIGHT hold, DAWN fade-up,
// advanced one step per frame-start event; drives the sky background blend weight.
module twilight_fade_ctrl #(
   parameter logic [15:0] HOLD_FRAMES = 16'd600,
   parameter logic [7:0]  STEP_FRAMES = 8'd2,
   parameter logic [7:0]  FADE_STEP   = 8'd1
) (
   input  logic       clk_pix,
   input  logic       rst_n,
   input  logic       frame,
   input  logic       en,
   input  logic       force_day,
   output logic [7:0] fade_level,
   output logic [1:0] phase,
   output logic       night,
   output logic       cycle_done
);

   typedef enum logic [1:0] {
      DAY   = 2'd0,
      DUSK  = 2'd1,
      NIGHT = 2'd2,
      DAWN  = 2'd3
   } phase_e;

   phase_e      state_q;
   logic [7:0]  fade_q;
   logic [15:0] hold_cnt_q;
   logic [7:0]  step_cnt_q;
   logic        night_q;
   logic        done_q;

   logic        evt;
   logic        hold_last;
   logic        step_last;
   logic [7:0]  fade_dn_d;
   logic [8:0]  fade_up_sum;
   logic [7:0]  fade_up_d;

   // force_day is resolved first in the register block, so it is not folded in here
   assign evt       = frame & en;
   assign hold_last = (hold_cnt_q == (HOLD_FRAMES - 16'd1));
   assign step_last = (step_cnt_q == (STEP_FRAMES - 8'd1));

   // Saturating fade arithmetic: never wraps through 0 or 255
   assign fade_dn_d   = (fade_q > FADE_STEP) ? (fade_q - FADE_STEP) : 8'd0;
   assign fade_up_sum = {1'b0, fade_q} + {1'b0, FADE_STEP};
   assign fade_up_d   = fade_up_sum[8] ? 8'hFF : fade_up_sum[7:0];

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= DAY;
         fade_q     <= 8'hFF;
         hold_cnt_q <= 16'd0;
         step_cnt_q <= 8'd0;
         night_q    <= 1'b0;
         done_q     <= 1'b0;
      end else if (force_day) begin
         state_q    <= DAY;
         fade_q     <= 8'hFF;
         hold_cnt_q <= 16'd0;
         step_cnt_q <= 8'd0;
         night_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (evt) begin
            unique case (state_q)
               DAY: begin
                  if (hold_last) begin
                     state_q    <= DUSK;
                     hold_cnt_q <= 16'd0;
                     step_cnt_q <= 8'd0;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + 16'd1;
                  end
               end
               DUSK: begin
                  if (step_last) begin
                     step_cnt_q <= 8'd0;
                     fade_q     <= fade_dn_d;
                     if (fade_dn_d == 8'd0) begin
                        state_q    <= NIGHT;
                        hold_cnt_q <= 16'd0;
                        night_q    <= 1'b1;
                     end
                  end else begin
                     step_cnt_q <= step_cnt_q + 8'd1;
                  end
               end
               NIGHT: begin
                  if (hold_last) begin
                     state_q    <= DAWN;
                     hold_cnt_q <= 16'd0;
                     step_cnt_q <= 8'd0;
                     night_q    <= 1'b0;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + 16'd1;
                  end
               end
               DAWN: begin
                  if (step_last) begin
                     step_cnt_q <= 8'd0;
                     fade_q     <= fade_up_d;
                     if (fade_up_d == 8'hFF) begin
                        state_q    <= DAY;
                        hold_cnt_q <= 16'd0;
                        done_q     <= 1'b1;
                     end
                  end else begin
                     step_cnt_q <= step_cnt_q + 8'd1;
                  end
               end
               default: state_q <= DAY;
            endcase
         end
      end
   end

   assign fade_level = fade_q;
   assign phase      = state_q;
   assign night      = night_q;
   assign cycle_done = done_q;

endmodule

// File: tb/tb_twilight_fade_ctrl.sv
// Scoreboard bench: two sequencers (STEP_FRAMES 1 and 3) against a closed-form
// model that derives phase/fade from the number of events since the cycle began.
module tb_twilight_fade_ctrl;

   localparam int H   = 4;
   localparam int FS  = 64;
   localparam int SFA = 1;
   localparam int SFB = 3;

   logic       clk_pix = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame = 1'b0;
   logic       en = 1'b1;
   logic       force_day = 1'b0;

   logic [7:0] fade_a, fade_b;
   logic [1:0] phase_a, phase_b;
   logic       night_a, night_b, done_a, done_b;

   always #5 clk_pix = ~clk_pix;

   twilight_fade_ctrl #(.HOLD_FRAMES(16'(H)), .STEP_FRAMES(8'(SFA)), .FADE_STEP(8'(FS))) dut_a (
      .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .en(en), .force_day(force_day),
      .fade_level(fade_a), .phase(phase_a), .night(night_a), .cycle_done(done_a));

   twilight_fade_ctrl #(.HOLD_FRAMES(16'(H)), .STEP_FRAMES(8'(SFB)), .FADE_STEP(8'(FS))) dut_b (
      .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .en(en), .force_day(force_day),
      .fade_level(fade_b), .phase(phase_b), .night(night_b), .cycle_done(done_b));

   typedef struct packed {
      logic [1:0] ph;
      logic [7:0] fd;
      logic       nt;
      logic       cd;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t b;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   n_a = 0;
   int   n_b = 0;

   // Phase/fade after n events into the cycle, from the phase lengths alone
   function automatic obs_t model(input int n, input int sf, input logic cd);
      obs_t o;
      int   f;
      int   t;
      f = ((255 + FS - 1) / FS) * sf;
      o.cd = cd;
      if (n < H) begin
         o.ph = 2'd0; o.fd = 8'd255;
      end else if (n < H + f) begin
         t = 255 - ((n - H) / sf) * FS;
         o.ph = 2'd1; o.fd = 8'((t < 0) ? 0 : t);
      end else if (n < 2*H + f) begin
         o.ph = 2'd2; o.fd = 8'd0;
      end else begin
         t = ((n - 2*H - f) / sf) * FS;
         o.ph = 2'd3; o.fd = 8'((t > 255) ? 255 : t);
      end
      o.nt = (o.ph == 2'd2);
      return o;
   endfunction

   function automatic int advance(input int n, input int sf, output logic cd);
      int total;
      total = 2*H + 2*((255 + FS - 1) / FS) * sf;
      cd = 1'b0;
      if (!rst_n || force_day) return 0;
      if (frame && en) begin
         if (n + 1 == total) begin
            cd = 1'b1;
            return 0;
         end
         return n + 1;
      end
      return n;
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got ph=%0d fade=%0d night=%0b done=%0b, want ph=%0d fade=%0d night=%0b done=%0b",
                  name, act.ph, act.fd, act.nt, act.cd, exp.ph, exp.fd, exp.nt, exp.cd);
      end
   endtask

   task automatic drive(input bit r, input bit f, input bit e, input bit fd);
      exp_t x;
      logic cda, cdb;
      obs_t rst_exp;
      bit   was_up;
      @(negedge clk_pix);
      was_up = rst_n;
      rst_n = r; frame = f; en = e; force_day = fd;
      if (!r && was_up) begin
         // Reset is asynchronous: outputs must clear before any clock edge
         #1;
         rst_exp = '{ph: 2'd0, fd: 8'd255, nt: 1'b0, cd: 1'b0};
         check("async_rst_a", '{ph: phase_a, fd: fade_a, nt: night_a, cd: done_a}, rst_exp);
         check("async_rst_b", '{ph: phase_b, fd: fade_b, nt: night_b, cd: done_b}, rst_exp);
      end
      n_a = advance(n_a, SFA, cda);
      n_b = advance(n_b, SFB, cdb);
      x.a = model(n_a, SFA, cda);
      x.b = model(n_b, SFB, cdb);
      q.push_back(x);
   endtask

   task automatic pulse(input bit e);
      drive(1, 1, e, 0);
      drive(1, 0, e, 0);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk_pix);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            check("dut_a", '{ph: phase_a, fd: fade_a, nt: night_a, cd: done_a}, x.a);
            check("dut_b", '{ph: phase_b, fd: fade_b, nt: night_b, cd: done_b}, x.b);
         end
      end
   end

   initial begin : stim
      repeat (3) drive(0, 0, 1, 0);
      // DAY hold, DUSK down to 127 on the STEP_FRAMES=1 instance
      repeat (6) pulse(1);
      repeat (10) pulse(0);
      // Resume: next pulse takes fade to 63, then on into DAWN at 128
      repeat (8) pulse(1);
      drive(1, 1, 1, 1);
      drive(1, 0, 1, 0);
      // Into NIGHT, then reset asynchronously mid-night
      repeat (9) pulse(1);
      drive(0, 1, 1, 0);
      drive(1, 0, 1, 0);
      // Two uninterrupted full cycles, cycle_done exactly on the wrap
      repeat (40) pulse(1);
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 199) != 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) != 0),
               ($urandom_range(0, 99) == 0));
      end
      drive(1, 0, 1, 0);
      repeat (3) @(posedge clk_pix);
      #2;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
